// File: rtl/prog_clock_divider.sv
// Multi-channel programmable divider: per-channel 50% square wave plus one-cycle tick.
// Optional build macro PROG_CLKDIV_IMMEDIATE_LOAD_EN: a divisor write restarts the channel at once.
module prog_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 5000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] act_q, act_d;
      logic [CNT_W-1:0] pnd_q, pnd_d;
      logic             clk_q, clk_d;
      logic             tick_q, tick_d;
      logic             pend_q, pend_d;
      logic             wr_hit;
      logic             term;

      // Channel codes >= NUM_CH match no instance, so such writes fall away.
      assign wr_hit = wr_en && (wr_ch == CH_W'(gi));
      assign term   = en[gi] && (cnt_q == act_q);

      always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        act_d  = act_q;
        pnd_d  = pnd_q;
        pend_d = pend_q;
        if (sync) begin
          cnt_d  = '0;
          clk_d  = 1'b0;
          pend_d = 1'b0;
          if (wr_hit) begin
            act_d = wr_div;
            pnd_d = wr_div;
          end else if (pend_q) begin
            act_d = pnd_q;
          end
        end else begin
          if (en[gi]) begin
            if (term) begin
              cnt_d  = '0;
              clk_d  = ~clk_q;
              tick_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
`ifdef PROG_CLKDIV_IMMEDIATE_LOAD_EN
          // Restart the interval from the write; the output level is kept.
          if (wr_hit) begin
            cnt_d  = '0;
            clk_d  = clk_q;
            tick_d = 1'b0;
            act_d  = wr_div;
            pnd_d  = wr_div;
          end
          pend_d = 1'b0;
`else
          if (wr_hit && term) begin
            act_d  = wr_div;
            pnd_d  = wr_div;
            pend_d = 1'b0;
          end else if (wr_hit) begin
            pnd_d  = wr_div;
            pend_d = 1'b1;
          end else if (term && pend_q) begin
            act_d  = pnd_q;
            pend_d = 1'b0;
          end
`endif
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q  <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
          act_q  <= DEF_DIV;
          pnd_q  <= DEF_DIV;
          pend_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          clk_q  <= clk_d;
          tick_q <= tick_d;
          act_q  <= act_d;
          pnd_q  <= pnd_d;
          pend_q <= pend_d;
        end
      end

      assign clk_out[gi] = clk_q;
      assign tick[gi]    = tick_q;
      assign pend[gi]    = pend_q;
    end
  endgenerate

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider (3 channels so an out-of-range channel code exists).
module tb_prog_clock_divider;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] en = '0;
  logic              sync = 1'b0;
  logic              wr_en = 1'b0;
  logic [CH_W-1:0]   wr_ch = '0;
  logic [CNT_W-1:0]  wr_div = '0;
  logic [NUM_CH-1:0] clk_out, tick, pend;

  prog_clock_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(5000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_div(wr_div), .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   ch;
    int   cyc;
    logic lvl;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc;

  // Edge number since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: every tick pulse is matched against the next expected tick.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (tick[c]) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL tick_unexpected: ch %0d at edge %0d, none expected", c, cyc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.ch != c || e.cyc != cyc || e.lvl != clk_out[c]) begin
              fails++;
              $display("FAIL tick_event: got ch %0d edge %0d clk_out %0b, expected ch %0d edge %0d clk_out %0b",
                       c, cyc, clk_out[c], e.ch, e.cyc, e.lvl);
            end else begin
              $display("[TB] tick ch %0d edge %0d clk_out %0b ok", c, cyc, clk_out[c]);
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input int ch, input int c, input logic lvl);
    exp_t e;
    e.ch = ch; e.cyc = c; e.lvl = lvl;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] %s = %0h ok", name, act);
    end
  endtask

  // Returns #1 after rising edge n: inputs set afterwards apply to edge n+1.
  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_div = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_clk_out", 32'(clk_out), 0);
    check("reset_pend", 32'(pend), 0);
    rst_n = 1'b1;

    // Load D=9 into ch1 while idle, then sync applies it.
    write(2'd1, 16'd9);
    step_to(1);
    check("pend_after_write", 32'(pend), 32'b010);
    wr_en = 1'b0; sync = 1'b1;
    step_to(2);
    check("sync_clears_pend", 32'(pend), 0);
    check("sync_clk_out", 32'(clk_out), 0);
    sync = 1'b0; en = 3'b010;
    push_exp(1, 12, 1'b1); push_exp(1, 22, 1'b0);
    push_exp(1, 26, 1'b1); push_exp(1, 30, 1'b0); push_exp(1, 34, 1'b1);
    push_exp(1, 38, 1'b0); push_exp(1, 41, 1'b1);
    push_exp(1, 47, 1'b1);

    // Mid-interval write of D=3: deferred to the terminal count at edge 22.
    step_to(15);
    write(2'd1, 16'd3);
    step_to(16);
    check("pend_mid_interval", 32'(pend), 32'b010);
    wr_en = 1'b0;
    step_to(21);
    check("pend_before_tc", 32'(pend), 32'b010);
    step_to(22);
    check("pend_cleared_at_tc", 32'(pend), 0);

    // Write D=2 on the terminal-count cycle itself.
    step_to(37);
    write(2'd1, 16'd2);
    step_to(38);
    check("pend_write_on_tc", 32'(pend), 0);
    wr_en = 1'b0;

    // Pending D=0 on ch2, then sync mid-count with an out-of-range write.
    step_to(42);
    write(2'd2, 16'd0);
    step_to(43);
    check("pend_ch2", 32'(pend), 32'b100);
    check("clk_out_before_sync", 32'(clk_out), 32'b010);
    write(2'd3, 16'd7);
    sync = 1'b1;
    step_to(44);
    check("sync_mid_clk_out", 32'(clk_out), 0);
    check("sync_mid_tick", 32'(tick), 0);
    check("sync_mid_pend", 32'(pend), 0);
    sync = 1'b0;
    write(2'd3, 16'd1);
    step_to(45);
    check("bad_ch_write_pend", 32'(pend), 0);
    wr_en = 1'b0;

    // D=0 on ch2 with enable pattern 1,1,0,1.
    step_to(47);
    en = 3'b100;
    push_exp(2, 48, 1'b1); push_exp(2, 49, 1'b0); push_exp(2, 51, 1'b1);
    step_to(49);
    en = 3'b000;
    step_to(50);
    check("d0_disabled_tick", 32'(tick), 0);
    check("d0_disabled_clk_out", 32'(clk_out), 32'b010);
    en = 3'b100;
    step_to(51);
    en = 3'b000;
    step_to(52);
    check("clk_out_before_reset", 32'(clk_out), 32'b110);

    // Asynchronous reset between edges.
    rst_n = 1'b0;
    #1;
    check("async_rst_clk_out", 32'(clk_out), 0);
    check("async_rst_tick", 32'(tick), 0);
    check("async_rst_pend", 32'(pend), 0);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    // Release with all channels enabled: divisors are back to 5000.
    en = 3'b111;
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++)
      for (int c = 0; c < NUM_CH; c++)
        push_exp(c, 5001 * k, logic'(k % 2));
    step_to(5000);
    check("pend_default_run", 32'(pend), 0);
    check("tick_before_5001", 32'(tick), 0);
    step_to(10002);
    check("pend_default_run2", 32'(pend), 0);
    step_to(15004);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
